spi_slave: RTL and testbench

//  SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the far end of the spi master link.
//  Per frame: receives a CMD_WIDTH-bit command on spi_mosi, then shifts a RSP_WIDTH-bit response out on spi_miso.
//  The response word is fetched from local logic over a valid/ready handshake.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_edge_sync.sv | 36 +++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM states and SPI mode constants shared by the SPI master and slave
package spi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RSP, ST_TAIL} spi_state_e;
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with registered rise/fall pulses on the synchronized level
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign q = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder receiving a command and returning a handshaked response word
module spi_slave
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH = 8,
  parameter int RSP_WIDTH = 12,
  parameter int ADDR_LSB = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 spi_cs,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 cmd_valid,
  output logic [CMD_WIDTH-1:0] cmd_data,
  output logic [2:0]           cmd_addr,
  output logic                 rsp_ready,
  input  logic                 rsp_valid,
  input  logic [RSP_WIDTH-1:0] rsp_data,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 frame_err
);
  localparam int CW = $clog2(CMD_WIDTH + RSP_WIDTH + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WIDTH - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(CMD_WIDTH + RSP_WIDTH - 1);
  spi_state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CMD_WIDTH-2:0] cmd_sr_q, cmd_sr_d;
  logic [CMD_WIDTH-1:0] cmd_data_q, cmd_data_d, cmd_next;
  logic [RSP_WIDTH-1:0] rsp_sr_q, rsp_sr_d;
  logic rsp_ready_q, rsp_ready_d, loaded_q, loaded_d, first_q, first_d;
  logic miso_q, miso_d, oe_q, oe_d;
  logic cmd_valid_q, cmd_valid_d, frame_done_q, frame_done_d;
  logic underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic cs_lvl, cs_rise, cs_fall, sck_lvl, sck_rise, sck_fall;
  logic mosi, mosi_rise, mosi_fall, hs, shift_in, shift_out, unused;
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(sys_clk), .rst(sys_rst), .d(spi_cs), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(sys_clk), .rst(sys_rst), .d(spi_sck), .q(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(sys_clk), .rst(sys_rst), .d(spi_mosi), .q(mosi), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused = &{1'b0, cs_lvl, sck_lvl, mosi_rise, mosi_fall};
  assign shift_in = (SPI_CPOL ^ SPI_CPHA) ? sck_fall : sck_rise;
  assign shift_out = (SPI_CPOL ^ SPI_CPHA) ? sck_rise : sck_fall;
  assign hs = rsp_valid && rsp_ready_q;
  assign cmd_next = {cmd_sr_q, mosi};
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_sr_d = cmd_sr_q;
    cmd_data_d = cmd_data_q;
    rsp_sr_d = rsp_sr_q;
    rsp_ready_d = rsp_ready_q;
    loaded_d = loaded_q;
    first_d = first_q;
    miso_d = miso_q;
    oe_d = oe_q;
    cmd_valid_d = 1'b0;
    frame_done_d = 1'b0;
    underrun_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q != ST_IDLE && cs_rise) begin
      frame_done_d = state_q == ST_TAIL;
      frame_err_d = state_q != ST_TAIL;
      rsp_ready_d = 1'b0;
      oe_d = 1'b0;
      miso_d = 1'b0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d = ST_CMD;
          bit_cnt_d = '0;
          oe_d = 1'b1;
          miso_d = 1'b0;
        end
        ST_CMD: if (shift_in) begin
          cmd_sr_d = cmd_next[CMD_WIDTH-2:0];
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CMD_LAST) begin
            cmd_data_d = cmd_next;
            cmd_valid_d = 1'b1;
            rsp_ready_d = 1'b1;
            loaded_d = 1'b0;
            first_d = 1'b1;
            state_d = ST_RSP;
          end
        end
        ST_RSP: begin
          if (hs) begin
            rsp_sr_d = rsp_data;
            rsp_ready_d = 1'b0;
            loaded_d = 1'b1;
          end
          if (shift_out) begin
            if (first_q && !(loaded_q || hs)) begin
              underrun_d = 1'b1;
              rsp_ready_d = 1'b0;
              rsp_sr_d = '0;
              miso_d = 1'b0;
            end else begin
              miso_d = rsp_sr_d[RSP_WIDTH-1];
              rsp_sr_d = rsp_sr_d << 1;
            end
            first_d = 1'b0;
          end
          if (shift_in) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == FRAME_LAST) begin
              state_d = ST_TAIL;
              miso_d = 1'b0;
            end
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      bit_cnt_q <= '0;
      cmd_sr_q <= '0;
      cmd_data_q <= '0;
      rsp_sr_q <= '0;
      rsp_ready_q <= 1'b0;
      loaded_q <= 1'b0;
      first_q <= 1'b0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_sr_q <= cmd_sr_d;
      cmd_data_q <= cmd_data_d;
      rsp_sr_q <= rsp_sr_d;
      rsp_ready_q <= rsp_ready_d;
      loaded_q <= loaded_d;
      first_q <= first_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      cmd_valid_q <= cmd_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign spi_miso = miso_q;
  assign spi_miso_oe = oe_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_data = cmd_data_q;
  assign cmd_addr = cmd_data_q[ADDR_LSB+:3];
  assign rsp_ready = rsp_ready_q;
  assign frame_done = frame_done_q;
  assign underrun = underrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized mode-0 master plus scoreboard checking commands, response bits and frame pulses
module tb_spi_slave;
  localparam int HALF = 500;
  typedef struct {bit err; logic [11:0] miso; int und;} frame_t;
  typedef struct {bit en; logic [11:0] data; int dly;} plan_t;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic spi_cs = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, cmd_valid, rsp_ready, rsp_valid, frame_done, underrun, frame_err;
  logic [7:0] cmd_data;
  logic [2:0] cmd_addr;
  logic [11:0] rsp_data;
  int n_cmp = 0, n_bad = 0, und_seen = 0, rx_cnt = 0;
  logic [11:0] miso_word = '0;
  logic [7:0] exp_cmd[$];
  frame_t frm_q[$];
  plan_t plan_q[$];
  spi_slave dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_addr(cmd_addr), .rsp_ready(rsp_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .frame_done(frame_done), .underrun(underrun), .frame_err(frame_err)
  );
  always #10 sys_clk = ~sys_clk;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_zero(input string name);
    check(name, int'({spi_miso, spi_miso_oe, cmd_valid, rsp_ready, frame_done, underrun, frame_err, cmd_addr, cmd_data}), 0);
  endtask
  always @(negedge spi_cs) begin
    rx_cnt = 0;
    miso_word = '0;
  end
  always @(posedge spi_sck) if (!spi_cs) begin
    rx_cnt++;
    if (rx_cnt > 8 && rx_cnt <= 20) miso_word = {miso_word[10:0], spi_miso};
  end
  always @(negedge sys_clk) if (!sys_rst) begin
    frame_t f;
    logic [7:0] c;
    if (underrun) und_seen++;
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) check("unexpected_cmd_valid", 1, 0);
      else begin
        c = exp_cmd.pop_front();
        check("cmd_data", int'(cmd_data), int'(c));
        check("cmd_addr", int'(cmd_addr), (int'(c) / 8) % 8);
      end
    end
    if (frame_done || frame_err) begin
      if (frm_q.size() == 0) check("unexpected_frame_end", 1, 0);
      else begin
        f = frm_q.pop_front();
        check("frame_err", int'(frame_err), int'(f.err));
        check("frame_done", int'(frame_done), int'(!f.err));
        if (!f.err) check("miso_word", int'(miso_word), int'(f.miso));
        check("underrun_count", und_seen, f.und);
      end
      und_seen = 0;
    end
  end
  initial begin
    plan_t p;
    int k;
    rsp_valid = 1'b0;
    rsp_data = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (cmd_valid && !sys_rst && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p.en) begin
          repeat (p.dly) @(posedge sys_clk);
          #1;
          rsp_valid = 1'b1;
          rsp_data = p.data;
          k = 0;
          while (!rsp_ready && k < 40) begin
            @(posedge sys_clk);
            #1;
            k++;
          end
          check("rsp_ready_before_hs", int'(rsp_ready), 1);
          @(posedge sys_clk);
          #1;
          rsp_valid = 1'b0;
          rsp_data = '0;
        end
      end
    end
  end
  task automatic sck_cycle(input logic b);
    spi_mosi = b;
    #HALF;
    spi_sck = 1'b1;
    #HALF;
    spi_sck = 1'b0;
  endtask
  task automatic frame(input logic [7:0] cmd, input int n, input bit en, input logic [11:0] rsp, input int dly);
    frame_t f;
    if (n >= 8) begin
      exp_cmd.push_back(cmd);
      plan_q.push_back('{en, rsp, dly});
    end
    spi_cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      sck_cycle(i < 8 ? cmd[7-i] : 1'($urandom));
      if (i == 2) check("oe_in_frame", int'(spi_miso_oe), 1);
    end
    #HALF;
    f.err = n != 20;
    f.miso = en ? rsp : 12'h000;
    f.und = (n >= 8 && !en) ? 1 : 0;
    frm_q.push_back(f);
    spi_cs = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("oe_after_cs", int'(spi_miso_oe), 0);
    check("rsp_ready_after_cs", int'(rsp_ready), 0);
    #(2 * HALF);
  endtask
  initial begin
    logic [7:0] c;
    logic [11:0] r;
    logic [11:0] rsps[4];
    int n;
    rsps = '{12'h80F, 12'h80F, 12'h83F, 12'h8FF};
    repeat (5) @(negedge sys_clk);
    check_zero("reset_outputs");
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_zero("idle_outputs");
    frame(8'b0010_0000, 20, 1'b1, 12'h80F, 0);
    for (int a = 0; a < 4; a++) frame(8'(32'(a + 4) * 8), 20, 1'b1, rsps[a], 3);
    frame(8'h3A, 20, 1'b0, 12'h000, 0);
    frame(8'h15, 5, 1'b0, 12'h000, 0);
    frame(8'h28, 20, 1'b1, 12'h5A5, 5);
    frame(8'h30, 14, 1'b1, 12'hFFF, 1);
    frame(8'h38, 20, 1'b1, 12'h123, 7);
    for (int i = 0; i < 20; i++) begin
      c = 8'($urandom);
      r = 12'($urandom);
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 19) : 20;
      frame(c, n, $urandom_range(0, 4) != 0, r, $urandom_range(0, 15));
    end
    c = 8'h2C;
    exp_cmd.push_back(c);
    plan_q.push_back('{1'b1, 12'hABC, 2});
    spi_cs = 1'b0;
    for (int i = 0; i < 12; i++) sck_cycle(i < 8 ? c[7-i] : 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_zero("mid_frame_reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_zero("after_reset_release");
    for (int i = 0; i < 10; i++) sck_cycle(1'($urandom));
    repeat (5) @(negedge sys_clk);
    check_zero("cs_low_after_reset");
    spi_cs = 1'b1;
    repeat (10) @(negedge sys_clk);
    check_zero("cs_high_after_reset");
    #(2 * HALF);
    frame(8'h20, 20, 1'b1, 12'h80F, 4);
    repeat (20) @(negedge sys_clk);
    check("exp_cmd_drained", exp_cmd.size(), 0);
    check("frames_drained", frm_q.size(), 0);
    check("plans_drained", plan_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
